msrr8_ctrl: RTL



---
 rtl/msrr8_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/msrr8_ctrl.sv
// msrr8_ctrl: command sequencer driving sel/Sin of the msrr8dff rotate/shift register
module msrr8_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] load_data,
    output logic [1:0]       sel,
    output logic             sin_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LOAD, ROT2, ROT1, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-2:0]    cnt2_q, cnt2_d;
    logic             rem_q, rem_d;
    logic [1:0]       sel_q, sel_d;
    logic             sin_q, sin_d, busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        cnt2_d  = cnt2_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (start) begin
                buf_d   = op == 2'b10 ? load_data : '0;
                cnt_d   = CW'(WIDTH);
                cnt2_d  = amt[AW-1:1];
                rem_d   = amt[0];
                state_d = op[1] ? LOAD :
                          op == 2'b01 && amt[AW-1:1] != '0 ? ROT2 :
                          op == 2'b01 && amt[0] ? ROT1 : DONE;
            end
            LOAD: begin
                buf_d   = buf_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CW'(1) ? DONE : LOAD;
            end
            ROT2: begin
                cnt2_d  = cnt2_q - 1'b1;
                state_d = cnt2_q != (AW-1)'(1) ? ROT2 : rem_q ? ROT1 : DONE;
            end
            ROT1:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they align with state_q
        sel_d  = state_d == LOAD ? 2'b11 : state_d == ROT2 ? 2'b10 :
                 state_d == ROT1 ? 2'b01 : 2'b00;
        sin_d  = state_d == LOAD && buf_d[0];
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            cnt2_q  <= '0;
            rem_q   <= 1'b0;
            sel_q   <= 2'b00;
            sin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            cnt2_q  <= cnt2_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            sin_q   <= sin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign sel     = sel_q;
    assign sin_out = sin_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule
